// File: rtl/xg_pon_burst_sequencer.sv
// rtl/xg_pon_burst_sequencer.sv - XG-PON upstream burst sequencer
// Hunts preamble/delimiter, gates payload until tlast or overrun, then holds a guard gap.
module xg_pon_burst_sequencer #(
  parameter int DELIM_TIMEOUT   = 64,
  parameter int MAX_BURST_WORDS = 2048,
  parameter int GUARD_CYCLES    = 8,
  parameter int CNT_W           = 16
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic             enable_in,
  input  logic             data_valid_in,
  input  logic             preamble_det_in,
  input  logic             delim_det_in,
  input  logic             tlast_det_in,
  output logic             preamble_rst_out,
  output logic             delim_rst_out,
  output logic             fcs_rst_out,
  output logic             payload_en_out,
  output logic             burst_end_out,
  output logic [2:0]       state_out,
  output logic [CNT_W-1:0] burst_ok_cnt_out,
  output logic [CNT_W-1:0] delim_tmo_cnt_out,
  output logic [CNT_W-1:0] overrun_cnt_out
);

  localparam int TMR_W = $clog2(DELIM_TIMEOUT + 1);
  localparam int WRD_W = $clog2(MAX_BURST_WORDS + 1);
  localparam logic [TMR_W-1:0] TMO_LIM = TMR_W'(DELIM_TIMEOUT);
  localparam logic [WRD_W-1:0] WRD_LIM = WRD_W'(MAX_BURST_WORDS);
  localparam logic [7:0]       GRD_LIM = 8'(GUARD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_HUNT_PRE   = 3'd1,
    S_HUNT_DELIM = 3'd2,
    S_PAYLOAD    = 3'd3,
    S_GUARD      = 3'd4
  } state_t;

  state_t           state;
  logic             pre_q, delim_q, tlast_q;
  logic [TMR_W-1:0] timer;
  logic [WRD_W-1:0] word_cnt;
  logic [7:0]       guard_cnt;

  logic             pre_edge, delim_edge, tlast_edge;
  logic [TMR_W-1:0] timer_inc;
  logic [WRD_W-1:0] word_inc;

  // Previous samples update every cycle, so a level already high on state entry never looks like an edge.
  always_comb begin
    pre_edge   = preamble_det_in & ~pre_q;
    delim_edge = delim_det_in & ~delim_q;
    tlast_edge = tlast_det_in & ~tlast_q;
    timer_inc  = timer + {{(TMR_W-1){1'b0}}, data_valid_in};
    word_inc   = word_cnt + {{(WRD_W-1){1'b0}}, data_valid_in};
  end

  assign state_out = state;

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state             <= S_IDLE;
      pre_q             <= 1'b0;
      delim_q           <= 1'b0;
      tlast_q           <= 1'b0;
      timer             <= '0;
      word_cnt          <= '0;
      guard_cnt         <= '0;
      preamble_rst_out  <= 1'b0;
      delim_rst_out     <= 1'b0;
      fcs_rst_out       <= 1'b0;
      payload_en_out    <= 1'b0;
      burst_end_out     <= 1'b0;
      burst_ok_cnt_out  <= '0;
      delim_tmo_cnt_out <= '0;
      overrun_cnt_out   <= '0;
    end else begin
      pre_q            <= preamble_det_in;
      delim_q          <= delim_det_in;
      tlast_q          <= tlast_det_in;
      preamble_rst_out <= 1'b0;
      delim_rst_out    <= 1'b0;
      fcs_rst_out      <= 1'b0;
      burst_end_out    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable_in) begin
            state            <= S_HUNT_PRE;
            preamble_rst_out <= 1'b1;
          end
        end
        S_HUNT_PRE: begin
          if (!enable_in) begin
            state <= S_IDLE;
          end else if (pre_edge) begin
            state         <= S_HUNT_DELIM;
            delim_rst_out <= 1'b1;
            timer         <= '0;
          end
        end
        S_HUNT_DELIM: begin
          if (!enable_in) begin
            state <= S_IDLE;
          end else if (delim_edge) begin
            state          <= S_PAYLOAD;
            payload_en_out <= 1'b1;
            fcs_rst_out    <= 1'b1;
            word_cnt       <= '0;
          end else begin
            timer <= timer_inc;
            if (timer_inc == TMO_LIM) begin
              state            <= S_GUARD;
              preamble_rst_out <= 1'b1;
              guard_cnt        <= '0;
              if (~&delim_tmo_cnt_out) delim_tmo_cnt_out <= delim_tmo_cnt_out + CNT_W'(1);
            end
          end
        end
        S_PAYLOAD: begin
          word_cnt <= word_inc;
          if (tlast_edge || (word_inc == WRD_LIM)) begin
            state            <= S_GUARD;
            payload_en_out   <= 1'b0;
            burst_end_out    <= 1'b1;
            preamble_rst_out <= 1'b1;
            guard_cnt        <= '0;
            // A tlast edge landing on the limit word is a clean burst, not an overrun.
            if (tlast_edge) begin
              if (~&burst_ok_cnt_out) burst_ok_cnt_out <= burst_ok_cnt_out + CNT_W'(1);
            end else begin
              if (~&overrun_cnt_out) overrun_cnt_out <= overrun_cnt_out + CNT_W'(1);
            end
          end
        end
        S_GUARD: begin
          if (guard_cnt == GRD_LIM) begin
            state <= enable_in ? S_HUNT_PRE : S_IDLE;
          end else begin
            guard_cnt <= guard_cnt + 8'd1;
          end
        end
        default: begin
          state          <= S_IDLE;
          payload_en_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xg_pon_burst_sequencer.sv
// tb/tb_xg_pon_burst_sequencer.sv - directed bench for xg_pon_burst_sequencer
module tb_xg_pon_burst_sequencer;

  logic       clk = 1'b0;
  logic       reset_n, enable, valid, pre, delim, tlast;
  logic       pre_rst, delim_rst, fcs_rst, payload_en, burst_end;
  logic [2:0] state;
  logic [1:0] ok_cnt, tmo_cnt, ovr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  int mon_pre = 0, mon_del = 0, mon_fcs = 0, mon_pay = 0, mon_end = 0, mon_grd = 0;
  int overlap = 0, wide = 0;
  logic last_pre = 1'b0, last_del = 1'b0, last_fcs = 1'b0, last_end = 1'b0;

  int s_pre, s_del, s_fcs, s_pay, s_end, s_grd;

  always #5 clk = ~clk;

  xg_pon_burst_sequencer #(
    .DELIM_TIMEOUT(64), .MAX_BURST_WORDS(2048), .GUARD_CYCLES(8), .CNT_W(2)
  ) dut (
    .clk_in(clk), .reset_n_in(reset_n), .enable_in(enable), .data_valid_in(valid),
    .preamble_det_in(pre), .delim_det_in(delim), .tlast_det_in(tlast),
    .preamble_rst_out(pre_rst), .delim_rst_out(delim_rst), .fcs_rst_out(fcs_rst),
    .payload_en_out(payload_en), .burst_end_out(burst_end), .state_out(state),
    .burst_ok_cnt_out(ok_cnt), .delim_tmo_cnt_out(tmo_cnt), .overrun_cnt_out(ovr_cnt)
  );

  always @(negedge clk) begin
    if (pre_rst) mon_pre++;
    if (delim_rst) mon_del++;
    if (fcs_rst) mon_fcs++;
    if (payload_en) mon_pay++;
    if (burst_end) mon_end++;
    if (state == 3'd4) mon_grd++;
    if ((int'(pre_rst) + int'(delim_rst) + int'(fcs_rst)) > 1) overlap++;
    if ((pre_rst && last_pre) || (delim_rst && last_del) || (fcs_rst && last_fcs) || (burst_end && last_end)) wide++;
    last_pre = pre_rst;
    last_del = delim_rst;
    last_fcs = fcs_rst;
    last_end = burst_end;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_burst(input int pay);
    pre = 1'b1; step(1); pre = 1'b0;
    delim = 1'b1; step(1); delim = 1'b0;
    step(pay - 1);
    tlast = 1'b1; step(1); tlast = 1'b0;
    step(8);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; valid = 1'b0; pre = 1'b0; delim = 1'b0; tlast = 1'b0;
    step(3);
    chk("rst_state", 32'(state), 0);
    chk("rst_payload_en", 32'(payload_en), 0);
    chk("rst_pulses", 32'({pre_rst, delim_rst, fcs_rst, burst_end}), 0);
    chk("rst_counters", 32'({ok_cnt, tmo_cnt, ovr_cnt}), 0);

    reset_n = 1'b1; step(2);
    chk("idle_hold", 32'(state), 0);
    enable = 1'b1; step(1);
    chk("idle_to_hunt_pre", 32'(state), 1);
    chk("arm_preamble_rst", 32'(pre_rst), 1);
    step(1);
    chk("preamble_rst_width", 32'(pre_rst), 0);

    // normal burst: delimiter 10 cycles after preamble, tlast 100 cycles after delimiter
    valid = 1'b1;
    s_pre = mon_pre; s_del = mon_del; s_fcs = mon_fcs; s_pay = mon_pay; s_end = mon_end; s_grd = mon_grd;
    pre = 1'b1; step(1);
    chk("pre_edge_state", 32'(state), 2);
    chk("delim_rst_pulse", 32'(delim_rst), 1);
    step(9);
    chk("hunt_delim_wait", 32'(state), 2);
    delim = 1'b1; step(1);
    chk("delim_edge_state", 32'(state), 3);
    chk("fcs_rst_pulse", 32'(fcs_rst), 1);
    chk("payload_en_rise", 32'(payload_en), 1);
    step(99);
    chk("payload_hold", 32'(state), 3);
    tlast = 1'b1; step(1);
    chk("tlast_state", 32'(state), 4);
    chk("tlast_burst_end", 32'(burst_end), 1);
    chk("tlast_payload_fall", 32'(payload_en), 0);
    chk("burst_ok_1", 32'(ok_cnt), 1);
    pre = 1'b0; delim = 1'b0; tlast = 1'b0;
    step(7);
    chk("guard_hold", 32'(state), 4);
    step(1);
    chk("guard_exit_hunt", 32'(state), 1);
    chk("norm_pre_rst_n", 32'(mon_pre - s_pre), 1);
    chk("norm_delim_rst_n", 32'(mon_del - s_del), 1);
    chk("norm_fcs_rst_n", 32'(mon_fcs - s_fcs), 1);
    chk("norm_payload_cycles", 32'(mon_pay - s_pay), 100);
    chk("norm_burst_end_n", 32'(mon_end - s_end), 1);
    chk("norm_guard_cycles", 32'(mon_grd - s_grd), 8);

    // delimiter timeout: 64 valid cycles with a 5-cycle valid gap in the middle
    s_pay = mon_pay;
    pre = 1'b1; step(1); pre = 1'b0;
    chk("tmo_enter", 32'(state), 2);
    step(30); valid = 1'b0; step(5); valid = 1'b1; step(33);
    chk("tmo_not_yet", 32'(state), 2);
    step(1);
    chk("tmo_state", 32'(state), 4);
    chk("tmo_count", 32'(tmo_cnt), 1);
    chk("tmo_no_payload", 32'(mon_pay - s_pay), 0);
    step(8);
    chk("tmo_guard_exit", 32'(state), 1);

    // stale delimiter level, then overrun with no tlast
    delim = 1'b1; step(2);
    chk("stale_hunt_pre", 32'(state), 1);
    pre = 1'b1; step(1); pre = 1'b0;
    chk("stale_enter_delim", 32'(state), 2);
    step(5);
    chk("stale_delim_ignored", 32'(state), 2);
    delim = 1'b0; step(1); delim = 1'b1; step(1);
    chk("fresh_delim_edge", 32'(state), 3);
    s_pay = mon_pay; s_end = mon_end;
    step(2047);
    chk("ovr_not_yet", 32'(state), 3);
    step(1);
    chk("ovr_state", 32'(state), 4);
    chk("ovr_count", 32'(ovr_cnt), 1);
    chk("ovr_ok_unchanged", 32'(ok_cnt), 1);
    chk("ovr_burst_end", 32'(burst_end), 1);
    delim = 1'b0; step(8);
    chk("ovr_guard_exit", 32'(state), 1);
    chk("ovr_payload_cycles", 32'(mon_pay - s_pay), 2048);
    chk("ovr_burst_end_n", 32'(mon_end - s_end), 1);

    // delimiter on the timeout cycle wins; tlast on the 2048th word counts as ok
    pre = 1'b1; step(1); pre = 1'b0;
    step(63);
    chk("lim_hunt_delim", 32'(state), 2);
    delim = 1'b1; step(1); delim = 1'b0;
    chk("delim_wins_at_limit", 32'(state), 3);
    chk("delim_wins_no_tmo", 32'(tmo_cnt), 1);
    step(2047);
    tlast = 1'b1; step(1); tlast = 1'b0;
    chk("tlast_at_limit_state", 32'(state), 4);
    chk("tlast_at_limit_ok", 32'(ok_cnt), 2);
    chk("tlast_at_limit_no_ovr", 32'(ovr_cnt), 1);
    step(8);

    // 2-bit counters saturate at 3
    run_burst(4);
    chk("ok_reach_max", 32'(ok_cnt), 3);
    run_burst(4);
    chk("ok_saturate", 32'(ok_cnt), 3);

    // reset in the middle of a payload
    pre = 1'b1; step(1); pre = 1'b0;
    delim = 1'b1; step(1); delim = 1'b0;
    step(5);
    chk("pre_reset_payload", 32'(state), 3);
    reset_n = 1'b0; step(1);
    chk("midrst_state", 32'(state), 0);
    chk("midrst_payload_en", 32'(payload_en), 0);
    chk("midrst_burst_end", 32'(burst_end), 0);
    chk("midrst_counters", 32'({ok_cnt, tmo_cnt, ovr_cnt}), 0);
    reset_n = 1'b1; step(1);
    chk("post_reset_hunt", 32'(state), 1);

    // enable handling in each state
    enable = 1'b0; step(1);
    chk("hunt_pre_disable", 32'(state), 0);
    enable = 1'b1; step(1);
    pre = 1'b1; step(1); pre = 1'b0;
    chk("reenter_hunt_delim", 32'(state), 2);
    enable = 1'b0; step(1);
    chk("hunt_delim_disable", 32'(state), 0);
    enable = 1'b1; step(1);
    pre = 1'b1; step(1); pre = 1'b0;
    delim = 1'b1; step(1); delim = 1'b0;
    enable = 1'b0; step(3);
    chk("payload_ignores_enable", 32'(state), 3);
    tlast = 1'b1; step(1); tlast = 1'b0;
    chk("disabled_tlast_guard", 32'(state), 4);
    chk("ok_after_reset", 32'(ok_cnt), 1);
    step(8);
    chk("guard_to_idle", 32'(state), 0);

    chk("rst_pulse_overlap", 32'(overlap), 0);
    chk("pulse_width", 32'(wide), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
